// File: rtl/btn_filter_pkg.sv
// Shared constants and helpers for the push-button debounce filter.
package btn_filter_pkg;

    localparam int BTNFLT_SYNC_STAGES_DEF   = 2;
    localparam int BTNFLT_STABLE_CYCLES_DEF = 8;

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Multi-flop synchroniser bringing the raw asynchronous button into the clock
// domain; every stage resets to RST_LEVEL so no false edge follows reset.
module btn_sync
    import btn_filter_pkg::*;
#(
    parameter int   SYNC_STAGES = BTNFLT_SYNC_STAGES_DEF,
    parameter logic RST_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stg;

    // Shift chain: stage 0 samples the pin, the last stage is the clean level.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg <= {SYNC_STAGES{RST_LEVEL}};
        end else begin
            stg <= {stg[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stg[SYNC_STAGES-1];

endmodule

// File: rtl/btn_filter.sv
// Push-button debouncer: synchronises BTN and accepts a new level only after
// STABLE_CYCLES consecutive agreeing samples.
// Optional macro BTNFLT_EDGE_EN adds one-cycle BTN_RISE / BTN_FALL pulses.
module btn_filter
    import btn_filter_pkg::*;
#(
    parameter int   SYNC_STAGES   = BTNFLT_SYNC_STAGES_DEF,
    parameter int   STABLE_CYCLES = BTNFLT_STABLE_CYCLES_DEF,
    parameter logic RST_LEVEL     = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN,
`ifdef BTNFLT_EDGE_EN
    output logic BTN_RISE,
    output logic BTN_FALL,
`endif
    output logic BTNQ
);

    localparam int            CW      = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic          bs;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          q_nxt;

    btn_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_LEVEL   (RST_LEVEL)
    ) u_sync (
        .clk (CLK),
        .rst (RST),
        .d   (BTN),
        .q   (bs)
    );

    // Qualification: count disagreeing samples, any agreement restarts the count.
    always_comb begin
        cnt_nxt = '0;
        q_nxt   = BTNQ;
        if (bs != BTNQ) begin
            if (cnt == CNT_MAX) begin
                q_nxt = bs;
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end
    end

    // State registers for the counter and the accepted level.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt  <= '0;
            BTNQ <= RST_LEVEL;
        end else begin
            cnt  <= cnt_nxt;
            BTNQ <= q_nxt;
        end
    end

`ifdef BTNFLT_EDGE_EN
    // Edge pulses registered on the same edge that updates BTNQ.
    always_ff @(posedge CLK) begin
        if (RST) begin
            BTN_RISE <= 1'b0;
            BTN_FALL <= 1'b0;
        end else begin
            BTN_RISE <= q_nxt & ~BTNQ;
            BTN_FALL <= ~q_nxt & BTNQ;
        end
    end
`endif

endmodule

// File: tb/tb_btn_filter.sv
// Self-checking bench for btn_filter: directed scenarios plus random chatter,
// checked against a history-window reference model.
module tb_btn_filter;
    import btn_filter_pkg::*;

    localparam int   SS   = BTNFLT_SYNC_STAGES_DEF;
    localparam int   SC   = BTNFLT_STABLE_CYCLES_DEF;
    localparam logic RL   = 1'b0;
    localparam int   MAXE = 16384;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic BTN = 1'b1;
    logic BTNQ;
`ifdef BTNFLT_EDGE_EN
    logic BTN_RISE;
    logic BTN_FALL;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    btn_filter #(
        .SYNC_STAGES   (SS),
        .STABLE_CYCLES (SC),
        .RST_LEVEL     (RL)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .BTN      (BTN),
`ifdef BTNFLT_EDGE_EN
        .BTN_RISE (BTN_RISE),
        .BTN_FALL (BTN_FALL),
`endif
        .BTNQ     (BTNQ)
    );

    always #5 CLK = ~CLK;

    // Reference model: raw sample history per edge; the output flips when the
    // last SC synchronised samples all differ from it and none of those edges
    // precede the most recent reset or flip.
    logic samp [0:MAXE-1];
    int   n    = -1;
    int   last = 0;
    logic mq    = RL;
    logic mrise = 1'b0;
    logic mfall = 1'b0;

    function automatic logic bsat(input int j);
        return (j - SS < 0) ? RL : samp[j - SS];
    endfunction

    always @(posedge CLK) begin
        logic flip;
        n = n + 1;
        if (RST) begin
            for (int k = 0; k < SS; k++)
                if (n - k >= 0) samp[n - k] = RL;
            mq    = RL;
            last  = n;
            mrise = 1'b0;
            mfall = 1'b0;
        end else begin
            samp[n] = BTN;
            flip = 1'b1;
            for (int j = n - SC + 1; j <= n; j++)
                if (j <= last || bsat(j) == mq) flip = 1'b0;
            mrise = 1'b0;
            mfall = 1'b0;
            if (flip) begin
                mq    = ~mq;
                last  = n;
                mrise = mq;
                mfall = ~mq;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    logic prevq   = RL;
    logic prevtog = 1'b0;
    int   ntog    = 0;
    int   nfall   = 0;

    // One cycle: wait for the falling edge and compare all outputs to the model.
    task automatic tick(input string tag);
        logic tog;
        @(negedge CLK);
        chk(tag, {31'd0, BTNQ}, {31'd0, mq});
`ifdef BTNFLT_EDGE_EN
        chk({tag, "_rise"}, {31'd0, BTN_RISE}, {31'd0, mrise});
        chk({tag, "_fall"}, {31'd0, BTN_FALL}, {31'd0, mfall});
        if (BTN_FALL === 1'b1) nfall++;
`endif
        tog = (BTNQ !== prevq);
        chk("no_double_toggle", {31'd0, tog & prevtog}, 32'd0);
        if (tog) ntog++;
        prevtog = tog;
        prevq   = BTNQ;
    endtask

    task automatic ticks(input string tag, input int k);
        for (int i = 0; i < k; i++) tick(tag);
    endtask

    // Two cycles of half-period chatter ending on fin; called just after a negedge.
    task automatic chatter(input logic fin);
        for (int i = 0; i < 2; i++) begin
            #2 BTN = fin;
            #5 BTN = ~fin;
            tick("chatter");
        end
        #2 BTN = fin;
    endtask

    initial begin
        int lat;
        int off;
        logic v;

        // 1: reset held two cycles with BTN=1
        RST = 1'b1;
        BTN = 1'b1;
        tick("reset");
        chk("reset_q0", {31'd0, BTNQ}, 32'd0);
        tick("reset");
        chk("reset_q1", {31'd0, BTNQ}, 32'd0);
        RST = 1'b0;
        prevq = BTNQ;
        prevtog = 1'b0;
        ticks("post_reset_hold", 9);
        chk("post_reset_still_low", {31'd0, BTNQ}, 32'd0);
        ticks("post_reset_qual", 3);
        chk("post_reset_high", {31'd0, BTNQ}, 32'd1);

        // 2: clean press latency
        BTN = 1'b0;
        ticks("release_idle", 15);
        chk("idle_low", {31'd0, BTNQ}, 32'd0);
        BTN = 1'b1;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            tick("clean_press");
            lat++;
            if (BTNQ === 1'b1) break;
        end
        chk("press_latency", lat, 32'd10);
        ticks("press_hold", 5);

        // 3: chattering press
        BTN = 1'b0;
        ticks("pre_chatter", 15);
        ntog = 0;
        chatter(1'b1);
        ticks("chatter_press_hold", 30);
        chk("chatter_press_edges", ntog, 32'd1);
        chk("chatter_press_level", {31'd0, BTNQ}, 32'd1);

        // 4: chattering release
        ntog  = 0;
        nfall = 0;
        chatter(1'b0);
        ticks("chatter_release_hold", 50);
        chk("chatter_release_edges", ntog, 32'd1);
        chk("chatter_release_level", {31'd0, BTNQ}, 32'd0);
`ifdef BTNFLT_EDGE_EN
        chk("chatter_release_fall_pulses", nfall, 32'd1);
`endif

        // 5: seven-cycle glitch never qualifies
        ntog = 0;
        BTN = 1'b1;
        ticks("glitch_high", 7);
        BTN = 1'b0;
        ticks("glitch_after", 20);
        chk("glitch_edges", ntog, 32'd0);

        // 6: reset mid-count
        BTN = 1'b1;
        ticks("pre_reset_count", 5);
        RST = 1'b1;
        tick("mid_reset");
        RST = 1'b0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            tick("after_mid_reset");
            lat++;
            if (BTNQ === 1'b1) break;
        end
        chk("reset_mid_latency", lat, 32'd10);

        // Random segments with sub-cycle change times and occasional reset
        for (int s = 0; s < 150; s++) begin
            v   = 1'($urandom_range(0, 1));
            off = $urandom_range(1, 8);
            if (off >= 5) off = off + 1;
            if ($urandom_range(0, 19) == 0) RST = 1'b1;
            #(off) BTN = v;
            ticks("random", $urandom_range(1, 14));
            RST = 1'b0;
        end
        ticks("random_tail", 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
